reg_file_bypass: RTL
====================

Name: reg_file_bypass

Overview:
- Parametrised multi-entry register file for the pipelined ARM datapath. It replaces ad hoc banks of fixed 64-bit registers.
- Provides 2 combinational read ports and 1 clocked write port with per-write enable.
- A hardwired zero register (XZR) always reads 0 and ignores writes.
- Write-to-read bypass lets a writeback-stage write be seen by a decode-stage read in the same cycle.

Parameters:
DATA_WIDTH, 64, bits per register entry; must be >0.
NUM_REGS, 32, number of entries; must be a power of 2 and ≥2.
ZERO_REG, 31, index hardwired to zero; must be <NUM_REGS. Set to NUM_REGS to disable the zero register.
ADDR_W, $clog2(NUM_REGS), address width; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high; clears every entry on the posedge while high.
wr_en  input  1  write enable.
wr_addr  input  ADDR_W  write index.
wr_data  input  DATA_WIDTH  write data.
rd_addr_a  input  ADDR_W  read port A index.
rd_addr_b  input  ADDR_W  read port B index.
rd_data_a  output  DATA_WIDTH  read port A data, combinational.
rd_data_b  output  DATA_WIDTH  read port B data, combinational.

Behaviour:
- One clock (clk); reset is synchronous and active-high (reset). No asynchronous paths into state.
- Reset: at the posedge with reset=1, all entries become 0 and wr_en is ignored. The first cycle after reset, every read returns 0.
- Write: at the posedge with reset=0, wr_en=1 and wr_addr≠ZERO_REG, entry[wr_addr] ← wr_data. All other entries hold. wr_en=0 means no entry changes.
- Zero register: writes to ZERO_REG are dropped. Reads of ZERO_REG return 0 in every cycle, including when bypass would otherwise match.
- Read: rd_data_x = entry[rd_addr_x] combinationally, with 0 added latency.
- Bypass: if reset=0, wr_en=1, wr_addr==rd_addr_x and rd_addr_x≠ZERO_REG, then rd_data_x = wr_data in the same cycle. After the posedge the stored value matches, so the output does not glitch across the edge.
- Bypass is suppressed while reset=1. Reads then show stored contents, and those contents are all 0 from the cycle after the first reset edge.
- Both read ports are independent. Both may address the same entry, and both may bypass simultaneously.
- Reset mid-operation: reset wins over a same-cycle write. The entry ends at 0, not wr_data.
- Out-of-range addresses cannot occur because NUM_REGS is a power of 2.
- Elaboration-time asserts: DATA_WIDTH>0, NUM_REGS is a power of 2 and ≥2, ZERO_REG≤NUM_REGS.
- No X on outputs after the first reset edge, given known inputs.

Decomposition:
- Package regfile_pkg:
  - default constants XREG_WIDTH=64, XREG_COUNT=32, XZR_INDEX=31;
  - typedef xreg_addr_t (logic [4:0]);
  - typedef xreg_data_t (logic [63:0]).
- Sub-module register_en, parametrised by DATA_WIDTH: one entry built from the team's dFF cells, with ports q, d, en, reset, clk.
  - When en=0, the entry recirculates q through a 2:1 mux into d.
  - reset clears the entry synchronously.
  - The top level instantiates NUM_REGS−1 of them in a generate loop, skipping ZERO_REG.
  - The top level also holds the write decoder (one-hot from wr_addr, gated by wr_en), two NUM_REGS:1 read muxes, and the bypass compare logic.

Test Plan:
- Reset clear: preload entries 0..30 with 64'hFFFF_FFFF_FFFF_FFFF, assert reset for 1 cycle → all reads on both ports return 64'h0 the next cycle.
- Basic write/read: write X5←64'h0123_4567_89AB_CDEF, next cycle set rd_addr_a=5, rd_addr_b=5 → both ports return 64'h0123_4567_89AB_CDEF; all other entries still 0.
- Bypass: in the same cycle, wr_en=1, wr_addr=7, wr_data=64'hDEAD_BEEF_0000_0001, rd_addr_a=7, rd_addr_b=6 → rd_data_a=64'hDEAD_BEEF_0000_0001 before the edge, rd_data_b=0. After the edge, rd_data_a holds the same value.
- Zero register: write X31←64'h1234 with wr_en=1, read port A at 31 in the same cycle and the next cycle → both 64'h0. X0..X30 are unchanged.
- Enable low and reset priority: wr_en=0, wr_addr=3, wr_data=64'hAAAA → X3 keeps its prior value 64'h5555. Then reset=1, wr_en=1, wr_addr=3, wr_data=64'hBBBB → X3=0 afterwards.
- Parametrised instance: DATA_WIDTH=8, NUM_REGS=4, ZERO_REG=3. Write regs 0..2 with 8'h11, 8'h22, 8'h33, then read all 4 addresses on both ports → 8'h11, 8'h22, 8'h33, 8'h00.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// The defaults describe the ARM X-register bank: 32 x 64-bit entries with XZR at index 31.
package regfile_pkg;

    localparam int XREG_WIDTH = 64;
    localparam int XREG_COUNT = 32;
    localparam int XZR_INDEX  = 31;

    typedef logic [4:0]  xreg_addr_t;
    typedef logic [63:0] xreg_data_t;

    // True when n is a positive power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/register_en.sv
// One register-file entry: a bank of D flip-flops with a load enable.
// With en low, q is fed back through a 2:1 mux so the entry holds its value.
module register_en
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XREG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH-1:0] w_d;

    // Hold mux: reload the current value unless a write is enabled.
    assign w_d = en ? d : r_q;

    // Entry storage; reset takes priority over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/reg_file_bypass.sv
// Register file with two combinational read ports, one clocked write port,
// a hardwired zero register and same-cycle write-to-read bypass.
// Setting ZERO_REG = NUM_REGS removes the zero register entirely.
module reg_file_bypass
    import regfile_pkg::*;
#(
    parameter  int DATA_WIDTH = XREG_WIDTH,
    parameter  int NUM_REGS   = XREG_COUNT,
    parameter  int ZERO_REG   = XZR_INDEX,
    localparam int ADDR_W     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    // One extra bit so that ZERO_REG == NUM_REGS never matches a real address.
    localparam logic [ADDR_W:0] ZERO_IDX = (ADDR_W + 1)'(ZERO_REG);

    // Parameter sanity checks, evaluated at elaboration.
    if (DATA_WIDTH <= 0) begin : g_chk_width
        $error("reg_file_bypass: DATA_WIDTH must be > 0");
    end
    if (!is_pow2(NUM_REGS) || (NUM_REGS < 2)) begin : g_chk_count
        $error("reg_file_bypass: NUM_REGS must be a power of 2 and >= 2");
    end
    if ((ZERO_REG < 0) || (ZERO_REG > NUM_REGS)) begin : g_chk_zero
        $error("reg_file_bypass: ZERO_REG must be in 0..NUM_REGS");
    end

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} == ZERO_IDX;
    endfunction

    logic [DATA_WIDTH-1:0] w_entry [NUM_REGS];
    logic                  w_bypass_a;
    logic                  w_bypass_b;

    // Storage: one enabled register per index, except the zero register which is a constant.
    // Each entry's enable is its slice of the one-hot write decode gated by wr_en;
    // the zero register has no storage, so writes to it simply have nowhere to land.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        if (gi == ZERO_REG) begin : g_zero
            assign w_entry[gi] = '0;
        end else begin : g_reg
            logic w_we;
            assign w_we = wr_en && (wr_addr == ADDR_W'(gi));
            register_en #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (w_we),
                .d     (wr_data),
                .q     (w_entry[gi])
            );
        end
    end

    // Bypass only for a live (non-reset) write to a real register at the same index.
    assign w_bypass_a = !reset && wr_en && (wr_addr == rd_addr_a) && !is_zero_reg(rd_addr_a);
    assign w_bypass_b = !reset && wr_en && (wr_addr == rd_addr_b) && !is_zero_reg(rd_addr_b);

    // Read port A: zero register first, then bypass, then stored entry.
    always_comb begin
        rd_data_a = w_entry[rd_addr_a];
        if (is_zero_reg(rd_addr_a)) begin
            rd_data_a = '0;
        end else if (w_bypass_a) begin
            rd_data_a = wr_data;
        end
    end

    // Read port B: same priority as port A, fully independent.
    always_comb begin
        rd_data_b = w_entry[rd_addr_b];
        if (is_zero_reg(rd_addr_b)) begin
            rd_data_b = '0;
        end else if (w_bypass_b) begin
            rd_data_b = wr_data;
        end
    end

endmodule
